// File: rtl/cpu_mem_responder_pkg.sv
// cpu_mem_responder_pkg
//   Shared types and helpers for the CPU memory responder.
//   - req_sz_e     : CPU request size encoding (8/16/32/48 bits).
//   - resp_state_e : responder FSM states.
//   - beat_count() : number of 16-bit memory beats per request size.
//   - beat_wdata() : halfword k of the LSB-aligned 32-bit write data.
package cpu_mem_responder_pkg;

   localparam int unsigned MemBeatWidth = 16;

   typedef enum logic [1:0] {
      ReqDataSz8  = 2'd0,
      ReqDataSz16 = 2'd1,
      ReqDataSz32 = 2'd2,
      ReqDataSz48 = 2'd3
   } req_sz_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBeat = 2'd1,
      StDone = 2'd2
   } resp_state_e;

   function automatic logic [1:0] beat_count(req_sz_e sz);
      logic [1:0] n;
      unique case (sz)
         ReqDataSz8:  n = 2'd1;
         ReqDataSz16: n = 2'd1;
         ReqDataSz32: n = 2'd2;
         ReqDataSz48: n = 2'd3;
         default:     n = 2'd1;
      endcase
      return n;
   endfunction

   // Beats beyond the 32-bit write data read as zero (only 48-bit fetches get there).
   function automatic logic [MemBeatWidth-1:0] beat_wdata(logic [31:0] wd, logic [1:0] k);
      logic [47:0] ext;
      ext = {16'h0000, wd};
      return ext[{k, 4'b0000} +: MemBeatWidth];
   endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if
//   Bundles the CPU request/response signals and the 16-bit memory beat port.
//   Modports:
//   - slave  : responder view (takes CPU requests, drives memory beats).
//   - master : environment view (CPU plus memory/arbiter side).
//   Parameter ADDR_W is the CPU byte-address width; mem_addr is a halfword address.
interface cpu_mem_responder_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              cpu_req_valid;
   logic              cpu_req_we;
   logic [1:0]        cpu_req_sz;
   logic [ADDR_W-1:0] cpu_req_addr;
   logic [31:0]       cpu_wr_data;
   logic              cpu_enable;
   logic [47:0]       cpu_data_in;
   logic              cpu_err;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-2:0] mem_addr;
   logic [1:0]        mem_be;
   logic [15:0]       mem_wdata;
   logic [15:0]       mem_rdata;
   logic              mem_ack;

   modport slave (
      input  cpu_req_valid, cpu_req_we, cpu_req_sz, cpu_req_addr, cpu_wr_data,
      output cpu_enable, cpu_data_in, cpu_err,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport master (
      output cpu_req_valid, cpu_req_we, cpu_req_sz, cpu_req_addr, cpu_wr_data,
      input  cpu_enable, cpu_data_in, cpu_err,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Splits a CPU read/write request of 8/16/32/48 bits into 16-bit beats on a
//   synchronous memory port and returns little-endian read data to the CPU.
//   The CPU is stalled (cpu_enable low) while a request is in flight.
//   Ports:
//   - clk, rst_n : clock, asynchronous active-low reset.
//   - bus        : cpu_mem_responder_if.slave (CPU request side + memory beat side).
//   Parameters:
//   - ADDR_W      : CPU byte-address width.
//   - ACK_TIMEOUT : wait cycles allowed per beat before the request aborts with cpu_err.
module cpu_mem_responder
   import cpu_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input logic                clk,
   input logic                rst_n,
   cpu_mem_responder_if.slave bus
);

   localparam int unsigned HwW   = ADDR_W - 1;
   localparam int unsigned WaitW = $clog2(ACK_TIMEOUT + 1);

   resp_state_e        state_q, state_d;
   logic [1:0]         beat_q, beat_d;
   logic [1:0]         nbeats_q, nbeats_d;
   logic               we_q, we_d;
   req_sz_e            sz_q, sz_d;
   logic               byte_hi_q, byte_hi_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [47:0]        shadow_q, shadow_d;
   logic [WaitW-1:0]   wait_q, wait_d;

   logic               cpu_enable_q, cpu_enable_d;
   logic [47:0]        cpu_data_q, cpu_data_d;
   logic               cpu_err_q, cpu_err_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic [HwW-1:0]     mem_addr_q, mem_addr_d;
   logic [1:0]         mem_be_q, mem_be_d;
   logic [15:0]        mem_wdata_q, mem_wdata_d;

   req_sz_e            req_sz;
   logic               req_illegal;
   logic               last_beat;
   logic               timed_out;

   assign req_sz      = req_sz_e'(bus.cpu_req_sz);
   // 48-bit is fetch-only; every multi-byte access must be halfword aligned.
   assign req_illegal = (req_sz == ReqDataSz48 && bus.cpu_req_we) ||
                        (req_sz != ReqDataSz8 && bus.cpu_req_addr[0]);
   assign last_beat   = (beat_q == nbeats_q - 2'd1);
   assign timed_out   = (wait_q == WaitW'(ACK_TIMEOUT - 1));

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      nbeats_d     = nbeats_q;
      we_d         = we_q;
      sz_d         = sz_q;
      byte_hi_d    = byte_hi_q;
      wdata_d      = wdata_q;
      shadow_d     = shadow_q;
      wait_d       = wait_q;
      cpu_enable_d = cpu_enable_q;
      cpu_data_d   = cpu_data_q;
      cpu_err_d    = 1'b0;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;

      unique case (state_q)
         StIdle: begin
            if (bus.cpu_req_valid && cpu_enable_q) begin
               if (req_illegal) begin
                  cpu_err_d = 1'b1;
               end else begin
                  we_d         = bus.cpu_req_we;
                  sz_d         = req_sz;
                  byte_hi_d    = bus.cpu_req_addr[0];
                  wdata_d      = bus.cpu_wr_data;
                  nbeats_d     = beat_count(req_sz);
                  beat_d       = 2'd0;
                  wait_d       = '0;
                  // Cleared so the final copy is already zero-extended.
                  shadow_d     = '0;
                  cpu_enable_d = 1'b0;
                  mem_req_d    = 1'b1;
                  mem_we_d     = bus.cpu_req_we;
                  mem_addr_d   = bus.cpu_req_addr[ADDR_W-1:1];
                  if (req_sz == ReqDataSz8) begin
                     mem_be_d    = bus.cpu_req_addr[0] ? 2'b10 : 2'b01;
                     mem_wdata_d = {bus.cpu_wr_data[7:0], bus.cpu_wr_data[7:0]};
                  end else begin
                     mem_be_d    = 2'b11;
                     mem_wdata_d = bus.cpu_wr_data[15:0];
                  end
                  state_d      = StBeat;
               end
            end
         end

         StBeat: begin
            if (bus.mem_ack) begin
               if (sz_q == ReqDataSz8) begin
                  shadow_d[7:0] = byte_hi_q ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
               end else begin
                  shadow_d[{beat_q, 4'b0000} +: MemBeatWidth] = bus.mem_rdata;
               end
               wait_d = '0;
               if (last_beat) begin
                  mem_req_d = 1'b0;
                  state_d   = StDone;
               end else begin
                  // Next beat registered now so mem_req stays high without a bubble.
                  beat_d      = beat_q + 2'd1;
                  mem_addr_d  = mem_addr_q + HwW'(1);
                  mem_wdata_d = beat_wdata(wdata_q, beat_q + 2'd1);
               end
            end else if (timed_out) begin
               mem_req_d    = 1'b0;
               cpu_err_d    = 1'b1;
               cpu_enable_d = 1'b1;
               state_d      = StIdle;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end

         StDone: begin
            if (!we_q) begin
               cpu_data_d = shadow_q;
            end
            cpu_enable_d = 1'b1;
            state_d      = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         beat_q       <= 2'd0;
         nbeats_q     <= 2'd0;
         we_q         <= 1'b0;
         sz_q         <= ReqDataSz8;
         byte_hi_q    <= 1'b0;
         wdata_q      <= '0;
         shadow_q     <= '0;
         wait_q       <= '0;
         cpu_enable_q <= 1'b1;
         cpu_data_q   <= '0;
         cpu_err_q    <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= 2'b00;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         nbeats_q     <= nbeats_d;
         we_q         <= we_d;
         sz_q         <= sz_d;
         byte_hi_q    <= byte_hi_d;
         wdata_q      <= wdata_d;
         shadow_q     <= shadow_d;
         wait_q       <= wait_d;
         cpu_enable_q <= cpu_enable_d;
         cpu_data_q   <= cpu_data_d;
         cpu_err_q    <= cpu_err_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign bus.cpu_enable  = cpu_enable_q;
   assign bus.cpu_data_in = cpu_data_q;
   assign bus.cpu_err     = cpu_err_q;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_be      = mem_be_q;
   assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder
//   Directed and randomized bench for cpu_mem_responder (ADDR_W=32, ACK_TIMEOUT=4).
//   Memory is a 256-halfword table indexed by mem_addr[7:0] with a programmable
//   ack delay; every acknowledged beat is logged and compared with a request model.
module tb_cpu_mem_responder;

   typedef struct packed {
      logic [30:0] addr;
      logic        we;
      logic [1:0]  be;
      logic [15:0] wd;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] mem [256];
   beat_t       beat_log[$];
   int          wait_cnt;
   int          ack_delay;
   logic        ack_en;
   logic [47:0] exp_data;
   int          n_cmp;
   int          n_fail;

   cpu_mem_responder_if #(.ADDR_W(32)) mif ();

   cpu_mem_responder #(
      .ADDR_W      (32),
      .ACK_TIMEOUT (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mif.mem_rdata = mem[mif.mem_addr[7:0]];
   assign mif.mem_ack   = ack_en && (wait_cnt >= ack_delay);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 0;
      end else if (mif.mem_req && mif.mem_ack) begin
         wait_cnt <= 0;
         beat_log.push_back(beat_t'({mif.mem_addr, mif.mem_we, mif.mem_be, mif.mem_wdata}));
      end else if (mif.mem_req) begin
         wait_cnt <= wait_cnt + 1;
      end else begin
         wait_cnt <= 0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd);
      mif.cpu_req_valid = 1'b1;
      mif.cpu_req_we    = we;
      mif.cpu_req_sz    = sz;
      mif.cpu_req_addr  = addr;
      mif.cpu_wr_data   = wd;
   endtask

   // Issues one request starting at a negedge and returns at the negedge where
   // the CPU is released again (or the error pulse was seen).
   task automatic run_req(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input int dly);
      int          n;
      int          stall;
      logic        legal;
      logic [30:0] ha;
      logic [30:0] hk;
      logic [47:0] exp_rd;
      logic [47:0] wd48;
      logic [1:0]  exp_be;
      logic [15:0] exp_wd;
      beat_t       b;

      legal = !((sz == 2'd3 && we) || (sz != 2'd0 && addr[0]));
      n     = (sz == 2'd3) ? 3 : (sz == 2'd2) ? 2 : 1;
      ha    = addr[31:1];
      wd48  = {16'h0000, wd};
      exp_be = (sz != 2'd0) ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
      exp_rd = '0;
      if (sz == 2'd0) begin
         exp_rd[7:0] = addr[0] ? mem[ha[7:0]][15:8] : mem[ha[7:0]][7:0];
      end else begin
         for (int k = 0; k < n; k++) begin
            hk = ha + 31'(k);
            exp_rd[k*16 +: 16] = mem[hk[7:0]];
         end
      end

      ack_delay = dly;
      beat_log.delete();
      drive(we, sz, addr, wd);
      @(posedge clk);
      @(negedge clk);
      mif.cpu_req_valid = 1'b0;

      if (!legal) begin
         check("err_pulse", 64'(mif.cpu_err), 64'd1);
         check("err_enable", 64'(mif.cpu_enable), 64'd1);
         check("err_no_req", 64'(mif.mem_req), 64'd0);
         @(negedge clk);
         check("err_one_cycle", 64'(mif.cpu_err), 64'd0);
         check("err_no_beats", 64'(beat_log.size()), 64'd0);
         check("err_data_hold", 64'(mif.cpu_data_in), 64'(exp_data));
      end else begin
         stall = 0;
         while (mif.cpu_enable === 1'b0 && stall < 200) begin
            stall++;
            @(negedge clk);
         end
         check("stall_cycles", 64'(stall), 64'(n * (dly + 1) + 1));
         check("no_err", 64'(mif.cpu_err), 64'd0);
         if (!we) exp_data = exp_rd;
         check("cpu_data", 64'(mif.cpu_data_in), 64'(exp_data));
         check("beat_count", 64'(beat_log.size()), 64'(n));
         for (int k = 0; k < n && k < beat_log.size(); k++) begin
            b  = beat_log[k];
            hk = ha + 31'(k);
            exp_wd = (sz == 2'd0) ? {wd[7:0], wd[7:0]} : wd48[k*16 +: 16];
            check("beat_addr", 64'(b.addr), 64'(hk));
            check("beat_we", 64'(b.we), 64'(we));
            check("beat_be", 64'(b.be), 64'(exp_be));
            if (we) check("beat_wdata", 64'(b.wd), 64'(exp_wd));
         end
      end
   endtask

   initial begin
      int cyc;
      n_cmp    = 0;
      n_fail   = 0;
      exp_data = '0;
      ack_en   = 1'b1;
      ack_delay = 0;
      mif.cpu_req_valid = 1'b0;
      mif.cpu_req_we    = 1'b0;
      mif.cpu_req_sz    = 2'd0;
      mif.cpu_req_addr  = '0;
      mif.cpu_wr_data   = '0;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h80] = 16'h1111;
      mem[8'h81] = 16'h2222;
      mem[8'h82] = 16'h3333;
      mem[8'h01] = 16'hABCD;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_enable", 64'(mif.cpu_enable), 64'd1);
      check("rst_data", 64'(mif.cpu_data_in), 64'd0);
      check("rst_err", 64'(mif.cpu_err), 64'd0);
      check("rst_req", 64'(mif.mem_req), 64'd0);
      check("rst_we", 64'(mif.mem_we), 64'd0);
      check("rst_addr", 64'(mif.mem_addr), 64'd0);
      check("rst_be", 64'(mif.mem_be), 64'd0);
      check("rst_wdata", 64'(mif.mem_wdata), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 48-bit fetch, ack tied high.
      run_req(1'b0, 2'd3, 32'h0000_0100, 32'h0, 0);
      check("fetch_data", 64'(mif.cpu_data_in), 64'h3333_2222_1111);

      // Byte read of the odd lane.
      run_req(1'b0, 2'd0, 32'h0000_0203, 32'h0, 0);
      check("byte_data", 64'(mif.cpu_data_in), 64'hAB);

      // 32-bit write with 3 wait cycles per beat; read data must hold.
      run_req(1'b1, 2'd2, 32'h0000_0040, 32'hDEAD_BEEF, 3);
      check("write_hold", 64'(mif.cpu_data_in), 64'hAB);

      // Misaligned halfword read and 48-bit write.
      run_req(1'b0, 2'd1, 32'h0000_0011, 32'h0, 0);
      run_req(1'b1, 2'd3, 32'h0000_0020, 32'h1234_5678, 0);

      // Ack never arrives: abort after 4 wait cycles.
      ack_en = 1'b0;
      drive(1'b0, 2'd1, 32'h0000_0022, 32'h0);
      @(posedge clk);
      @(negedge clk);
      mif.cpu_req_valid = 1'b0;
      check("to_req_high", 64'(mif.mem_req), 64'd1);
      cyc = 0;
      while (mif.cpu_err !== 1'b1 && cyc < 20) begin
         cyc++;
         @(negedge clk);
      end
      check("to_wait_cycles", 64'(cyc), 64'd4);
      check("to_req_drop", 64'(mif.mem_req), 64'd0);
      check("to_enable", 64'(mif.cpu_enable), 64'd1);
      check("to_data_hold", 64'(mif.cpu_data_in), 64'(exp_data));
      @(negedge clk);
      check("to_err_one_cycle", 64'(mif.cpu_err), 64'd0);
      ack_en = 1'b1;

      // Reset while the second beat of a 32-bit read is outstanding.
      ack_delay = 0;
      drive(1'b0, 2'd2, 32'h0000_0060, 32'h0);
      @(posedge clk);
      @(negedge clk);
      mif.cpu_req_valid = 1'b0;
      @(posedge clk);
      #2;
      check("rst_mid_req_before", 64'(mif.mem_req), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_req", 64'(mif.mem_req), 64'd0);
      check("rst_mid_enable", 64'(mif.cpu_enable), 64'd1);
      check("rst_mid_data", 64'(mif.cpu_data_in), 64'd0);
      exp_data = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_req(1'b0, 2'd2, 32'h0000_0060, 32'h0, 0);

      // Halfword address wraps past the top of the address space.
      run_req(1'b0, 2'd3, 32'hFFFF_FFFC, 32'h0, 1);

      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
         run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
                 $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's request interface.
- Accepts a read/write request of 8/16/32/48 bits from the CPU and splits it into halfword beats on a 16-bit synchronous memory port. Returns the assembled little-endian read data on the CPU's data input bus.
- Stalls the CPU via its enable input while a request is in flight.
- Sits between the CPU and the RAM/ROM arbiter.

Parameters:
- ADDR_W, 32, CPU byte-address width.
- ACK_TIMEOUT, 255, max cycles waiting on mem_ack per beat before aborting with error.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  CPU presents a request this cycle.
- cpu_req_we  in  1  1 = write, 0 = read.
- cpu_req_sz  in  2  0 = 8b, 1 = 16b, 2 = 32b, 3 = 48b (instruction fetch).
- cpu_req_addr  in  ADDR_W  byte address.
- cpu_wr_data  in  32  write data, little-endian, LSB-aligned.
- cpu_enable  out  1  CPU enable; low stalls the CPU.
- cpu_data_in  out  48  read data, zero-extended above the request size.
- cpu_err  out  1  one-cycle pulse: misaligned, illegal or timed-out request.
- mem_req  out  1  beat request to memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W-1  halfword address (cpu addr >> 1).
- mem_be  out  2  byte lane enables; bit0 = even byte.
- mem_wdata  out  16  write halfword.
- mem_rdata  in  16  read halfword; valid in the cycle mem_req && mem_ack.
- mem_ack  in  1  beat completes in any cycle where mem_req && mem_ack.

Behaviour:
- Reset (async, rst_n=0):
  - cpu_enable=1, cpu_data_in=0, cpu_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - State IDLE, counters cleared.
  - Reset mid-transfer aborts immediately: mem_req drops asynchronously and no partial data reaches cpu_data_in.
- States: IDLE, BEAT, DONE.
- IDLE:
  - On a rising edge with cpu_req_valid=1 and cpu_enable=1, capture we/sz/addr/wdata.
  - Legality check:
    - sz=3 with we=1 is illegal.
    - sz>=1 with addr[0]=1 is misaligned.
  - Illegal or misaligned: pulse cpu_err for 1 cycle, cpu_enable stays 1, state stays IDLE, no memory access.
  - Otherwise, at that same edge: cpu_enable<=0, mem_req<=1, beat 0 presented, state<=BEAT.
- Beat count: sz0 = 1; sz1 = 1; sz2 = 2; sz3 = 3.
- Beat k fields: mem_addr = (addr>>1)+k, mem_we = captured we.
- Byte accesses (sz0):
  - mem_be = addr[0] ? 2'b10 : 2'b01.
  - Write data replicated in both lanes of mem_wdata.
  - Read selects the matching byte.
- All other sizes: mem_be=2'b11; mem_wdata = wdata[16k+15:16k].
- BEAT:
  - On a cycle with mem_ack=1, read data goes into bits [16k+15:16k] of a shadow buffer and the next beat's address/data are registered; mem_req stays high, with no bubble between beats.
  - On the last beat's ack: mem_req<=0 and state<=DONE.
  - Wait-cycle counter resets each beat. If it reaches ACK_TIMEOUT: mem_req<=0, cpu_err pulses, cpu_data_in is unchanged, cpu_enable<=1, state<=IDLE.
- DONE (1 cycle):
  - Reads: cpu_data_in<=shadow, zero-extended.
  - cpu_enable<=1, state<=IDLE.
  - cpu_data_in holds until the next successful read; writes leave it unchanged.
- Latency with mem_ack tied high, request captured at edge T:
  - Beats complete at T+1..T+n.
  - cpu_enable and cpu_data_in update at edge T+n+1.
  - A new request may be accepted at edge T+n+2 or later.
- Wrap-around: address increment wraps modulo 2^(ADDR_W-1) halfwords.
- cpu_req_valid and other inputs are ignored outside IDLE.

Decomposition:
- Shared package pkg_cpu:
  - enum for request size (ReqDataSz8/16/32/48, 2 bits);
  - responder state enum;
  - beat-count lookup function;
  - constant mem_beat_width=16.
- No sub-module; the timeout counter and beat counter are inline.
- Optional sub-module: mem_beat_packer (combinational shadow-buffer insert/extract) if reused by a future DMA block.

Test Plan:
- 48-bit fetch at addr 0x100, ack tied high, memory halfwords 0x1111/0x2222/0x3333 → mem_addr 0x80, 0x81, 0x82 on consecutive cycles; cpu_data_in=0x333322221111; cpu_enable low for exactly 4 cycles.
- 8-bit read at addr 0x203, memory halfword 0xABCD → mem_be=2'b10, cpu_data_in=0x0000000000AB.
- 32-bit write 0xDEADBEEF at 0x40, ack delayed 3 cycles per beat → beats (0x20, 0xBEEF, be=11) then (0x21, 0xDEAD, be=11); cpu_data_in unchanged; cpu_enable returns high after the second ack + 1 cycle.
- Misaligned 16-bit read at 0x11, and a 48-bit write → cpu_err 1-cycle pulse each; mem_req never asserted; cpu_enable stays 1.
- mem_ack held low, ACK_TIMEOUT=4 → cpu_err pulses after 4 wait cycles; mem_req drops; cpu_enable=1; state IDLE.
- rst_n asserted during beat 2 of a 32-bit read → mem_req=0 and cpu_enable=1 immediately; cpu_data_in=0; the next request completes normally.
